battle_turn_ctrl: RTL and testbench
===================================

// Module: battle_turn_ctrl
// PURPOSE
//  Sequences one pokemon's damage datapath for each attack: DMG latch, HP calc, HP commit, bar decrement, white redraw.
//  Accepts one move per turn from the battle FSM via a valid/ready handshake.
//  Drives the datapath enables and reports turn completion, KO (battle over) and errors.
//  Sits between the top-level battle FSM and the damage/HP-bar datapath.
// PARAMETERS
//  MOVE_W          3     move code width (one-hot: 001 quick attack, 010 thunderbolt, 100 volt tackle)
//  TIMEOUT_CYCLES  1023  max cycles in DECR or DRAW before abort (only with WATCHDOG_EN)
//  TO_W            10    watchdog counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES
// PORTS
//  clock          in   1       single system clock
//  reset          in   1       synchronous, active-high
//  move_valid     in   1       battle FSM offers a move
//  move_sel       in   MOVE_W  offered move code
//  move_ready     out  1       = (state==IDLE) && !battle_over
//  move_code      out  MOVE_W  registered accepted code, drives datapath move input
//  dmg_reg_en     out  1       DMG register load enable
//  dmg_calc_en    out  1       HP-left calculator enable
//  hp_calc_en     out  1       current-HP register commit enable
//  decrement_en   out  1       bar x-decrement enable
//  draw_en        out  1       white-draw enable
//  done_decrement in   1       level: decrement reached target
//  done_damage    in   1       level: white draw finished
//  game_over      in   1       level: HP hit zero (valid from cycle after CALC)
//  turn_done      out  1       1-cycle pulse at end of each turn
//  battle_over    out  1       sticky KO flag
//  err_move       out  1       1-cycle pulse: invalid code consumed
//  timeout        out  1       1-cycle pulse: watchdog abort
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, move_code 3'b000. Datapath units use active-low reset; top level drives them with ~reset.
//  Accept: on the edge where move_valid && move_ready. move_code <= move_sel.
//   Valid codes 001/010/100 -> LOAD. Any other code (incl. 000) -> FINISH with err_move pulse; no enables raised.
//  States, with one-hot Moore outputs:
//   IDLE -> LOAD (dmg_reg_en, 1 cyc) -> CALC (dmg_calc_en, 1 cyc) -> COMMIT (hp_calc_en, 1 cyc)
//   -> DECR (decrement_en until done_decrement==1) -> DRAW (draw_en until done_damage==1) -> FINISH (turn_done, 1 cyc).
//  FINISH: if game_over -> OVER, battle_over <= 1; else -> IDLE.
//  OVER: absorbing; move_ready=0; only reset exits.
//  Latency: minimum accept-edge to turn_done = 6 cycles (DECR and DRAW each >= 1 cycle).
//  done_* sampled only in its own state. A stale done_* high on entry exits after that single cycle.
//  Each enable deasserts on the same edge its state exits. Never two enables high simultaneously.
//  move_valid while busy: ignored, ready stays 0. No queuing; the requester must hold valid.
//  move_code held stable from accept until the next accept, so DMG inputs are stable in LOAD.
//  Reset mid-turn: next edge IDLE, all enables 0, battle_over cleared.
//   The datapath is reset in the same cycle through ~reset.
// CONFIGURATION
//  WATCHDOG_EN defined: counter cleared on entry to DECR/DRAW, increments each cycle in state.
//   At count==TIMEOUT_CYCLES without done: -> FINISH and pulse timeout with turn_done.
//  Not defined: DECR/DRAW wait indefinitely; timeout tied 0; no counter logic.
// STRUCTURE
//  battle_pkg: state encoding localparams (IDLE..OVER), move code constants (MV_QA/MV_TB/MV_VT), MOVE_W.
//  Sub-module turn_watchdog (clear, count_en, expired), instantiated only under WATCHDOG_EN.
//  Single always block for the state register; combinational output decode.
// TESTING
//  Reset, then valid=1, sel=001, done_* tied high: pulses LOAD,CALC,COMMIT,DECR,DRAW in order, 1 cyc each; turn_done 6 cyc after accept.
//  sel=010, done_decrement rises 40 cyc after DECR entry: decrement_en high exactly 41 cyc, then draw_en.
//  game_over=1 in FINISH: battle_over=1, move_ready stays 0 for 100 cyc despite valid=1.
//  sel=011, then sel=000: err_move and turn_done pulse, no enables, ready returns next cycle.
//  reset asserted during DRAW: all enables 0 and IDLE on next edge; new accept works normally.
//  WATCHDOG_EN with TIMEOUT_CYCLES=15, done_decrement held 0: timeout+turn_done after 16 cyc in DECR. Without the macro: stays in DECR.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared definitions for the battle turn controller: move codes, state encoding.
package battle_pkg;

  localparam int MOVE_W = 3;

  // One-hot move codes offered by the battle FSM.
  localparam logic [MOVE_W-1:0] MV_QA = 3'b001;  // quick attack
  localparam logic [MOVE_W-1:0] MV_TB = 3'b010;  // thunderbolt
  localparam logic [MOVE_W-1:0] MV_VT = 3'b100;  // volt tackle

  // State encoding of the turn sequencer.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_CALC   = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_DECR   = 3'd4;
  localparam logic [2:0] ST_DRAW   = 3'd5;
  localparam logic [2:0] ST_FINISH = 3'd6;
  localparam logic [2:0] ST_OVER   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD   = ST_LOAD,
    S_CALC   = ST_CALC,
    S_COMMIT = ST_COMMIT,
    S_DECR   = ST_DECR,
    S_DRAW   = ST_DRAW,
    S_FINISH = ST_FINISH,
    S_OVER   = ST_OVER
  } state_t;

endpackage

// File: rtl/turn_watchdog.sv
// Cycle counter bounding how long the controller may wait in DECR or DRAW.
// Only instantiated when WATCHDOG_EN is defined.
module turn_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [TO_W-1:0] count;

  // Restart on state entry, then count every cycle spent waiting.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + TO_W'(1);
    end
  end

  assign expired = count_en && (count == TO_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/battle_turn_ctrl.sv
// Turn sequencer for one pokemon's damage datapath:
// DMG latch -> HP calc -> HP commit -> bar decrement -> white redraw -> finish.
// Optional feature macro: WATCHDOG_EN (abort DECR/DRAW after TIMEOUT_CYCLES).
module battle_turn_ctrl #(
  parameter int MOVE_W = battle_pkg::MOVE_W
`ifdef WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              move_valid,
  input  logic [MOVE_W-1:0] move_sel,
  output logic              move_ready,
  output logic [MOVE_W-1:0] move_code,
  output logic              dmg_reg_en,
  output logic              dmg_calc_en,
  output logic              hp_calc_en,
  output logic              decrement_en,
  output logic              draw_en,
  input  logic              done_decrement,
  input  logic              done_damage,
  input  logic              game_over,
  output logic              turn_done,
  output logic              battle_over,
  output logic              err_move,
  output logic              timeout
);

  import battle_pkg::*;

  state_t            state, state_n;
  logic [MOVE_W-1:0] move_code_n;
  logic              battle_over_n;
  logic              err_flag, err_flag_n;
  logic              accept;
  logic              sel_valid;

  assign move_ready = (state == S_IDLE) && !battle_over;
  assign accept     = move_valid && move_ready;
  assign sel_valid  = (move_sel == MOVE_W'(MV_QA)) ||
                      (move_sel == MOVE_W'(MV_TB)) ||
                      (move_sel == MOVE_W'(MV_VT));

`ifdef WATCHDOG_EN
  logic to_flag, to_flag_n;
  logic wd_clear, wd_count_en, wd_expired;

  assign wd_count_en = (state == S_DECR) || (state == S_DRAW);
  // Clear on every entry into a waiting state, including DECR -> DRAW.
  assign wd_clear    = (state_n != state) && ((state_n == S_DECR) || (state_n == S_DRAW));

  turn_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_turn_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .expired  (wd_expired)
  );
`endif

  // State register plus the per-turn bookkeeping it carries.
  // NOTE: every flop here uses <= so all registers update from the same pre-edge values.
  always_ff @(posedge clock) begin
    // NOTE: synchronous reset; the datapath sees the same reset through ~reset that cycle.
    if (reset) begin
      state       <= S_IDLE;
      move_code   <= '0;
      battle_over <= 1'b0;
      err_flag    <= 1'b0;
`ifdef WATCHDOG_EN
      to_flag     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      move_code   <= move_code_n;
      battle_over <= battle_over_n;
      err_flag    <= err_flag_n;
`ifdef WATCHDOG_EN
      to_flag     <= to_flag_n;
`endif
    end
  end

  // Next-state and register-update decode.
  always_comb begin
    // NOTE: hold-value defaults first so no path leaves a variable unassigned (no latches).
    state_n       = state;
    move_code_n   = move_code;
    battle_over_n = battle_over;
    err_flag_n    = err_flag;
`ifdef WATCHDOG_EN
    to_flag_n     = to_flag;
`endif
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          move_code_n = move_sel;
          err_flag_n  = !sel_valid;
          state_n     = sel_valid ? S_LOAD : S_FINISH;
        end
      end
      S_LOAD:   state_n = S_CALC;
      S_CALC:   state_n = S_COMMIT;
      S_COMMIT: state_n = S_DECR;
      S_DECR: begin
        if (done_decrement) begin
          state_n = S_DRAW;
        end
`ifdef WATCHDOG_EN
        else if (wd_expired) begin
          state_n   = S_FINISH;
          to_flag_n = 1'b1;
        end
`endif
      end
      S_DRAW: begin
        if (done_damage) begin
          state_n = S_FINISH;
        end
`ifdef WATCHDOG_EN
        else if (wd_expired) begin
          state_n   = S_FINISH;
          to_flag_n = 1'b1;
        end
`endif
      end
      S_FINISH: begin
        err_flag_n = 1'b0;
`ifdef WATCHDOG_EN
        to_flag_n  = 1'b0;
`endif
        if (game_over) begin
          state_n       = S_OVER;
          battle_over_n = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_OVER:  state_n = S_OVER;
      default: state_n = S_IDLE;
    endcase
  end

  // One-hot Moore outputs decoded from the current state.
  assign dmg_reg_en   = (state == S_LOAD);
  assign dmg_calc_en  = (state == S_CALC);
  assign hp_calc_en   = (state == S_COMMIT);
  assign decrement_en = (state == S_DECR);
  assign draw_en      = (state == S_DRAW);
  assign turn_done    = (state == S_FINISH);
  assign err_move     = (state == S_FINISH) && err_flag;
`ifdef WATCHDOG_EN
  assign timeout      = (state == S_FINISH) && to_flag;
`else
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Directed bench for battle_turn_ctrl with a turn scoreboard.
// Build with WATCHDOG_EN defined to exercise the timeout path (TIMEOUT_CYCLES=15).
module tb_battle_turn_ctrl;

`ifdef WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       move_valid;
  logic [2:0] move_sel;
  logic       move_ready;
  logic [2:0] move_code;
  logic       dmg_reg_en, dmg_calc_en, hp_calc_en, decrement_en, draw_en;
  logic       done_decrement, done_damage, game_over;
  logic       turn_done, battle_over, err_move, timeout;
  logic [4:0] en_vec;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] code;
    logic       err;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  always #5 clock = ~clock;

  assign en_vec = {dmg_reg_en, dmg_calc_en, hp_calc_en, decrement_en, draw_en};

  battle_turn_ctrl #(
    .MOVE_W (3)
`ifdef WATCHDOG_EN
    ,
    .TIMEOUT_CYCLES (15),
    .TO_W           (4)
`endif
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .move_valid     (move_valid),
    .move_sel       (move_sel),
    .move_ready     (move_ready),
    .move_code      (move_code),
    .dmg_reg_en     (dmg_reg_en),
    .dmg_calc_en    (dmg_calc_en),
    .hp_calc_en     (hp_calc_en),
    .decrement_en   (decrement_en),
    .draw_en        (draw_en),
    .done_decrement (done_decrement),
    .done_damage    (done_damage),
    .game_over      (game_over),
    .turn_done      (turn_done),
    .battle_over    (battle_over),
    .err_move       (err_move),
    .timeout        (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample and drive 2 time units after the rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  function automatic logic code_ok(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
  endfunction

  // Offer a move, push its expected outcome, hold valid for the accept edge only.
  task automatic offer(input logic [2:0] code, input logic to_exp);
    int i;
    exp_t e;
    i = 0;
    while (!move_ready && i < 50) begin
      tick();
      i++;
    end
    check("ready_before_accept", move_ready, 1);
    e.code = code;
    e.err  = !code_ok(code);
    e.to   = to_exp;
    sb_q.push_back(e);
    move_valid = 1'b1;
    move_sel   = code;
    tick();
    move_valid = 1'b0;
  endtask

  // Wait for turn_done; lat counts cycles after the accept edge.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!turn_done && lat < 60) begin
      tick();
      lat++;
    end
    check("turn_done_seen", turn_done, 1);
  endtask

  // Scoreboard and per-cycle invariants, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      check("enables_onehot", ($countones(en_vec) <= 1), 1);
      check("flag_without_done", (err_move | timeout) & ~turn_done, 0);
      if (turn_done) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_done", turn_done, 0);
        end else begin
          sb_e = sb_q.pop_front();
          check("sb_move_code", move_code, sb_e.code);
          check("sb_err_move", err_move, sb_e.err);
          check("sb_timeout", timeout, sb_e.to);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [4:0] exp_en [6];
    int n;
    int lat;

    exp_en = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00000};

    reset          = 1'b1;
    move_valid     = 1'b0;
    move_sel       = 3'b000;
    done_decrement = 1'b1;
    done_damage    = 1'b1;
    game_over      = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst_enables", en_vec, 5'b00000);
    check("rst_turn_done", turn_done, 0);
    check("rst_battle_over", battle_over, 0);
    check("rst_move_code", move_code, 3'b000);
    check("rst_err_timeout", {err_move, timeout}, 2'b00);
    reset = 1'b0;
    check("rst_ready", move_ready, 1);

    // Quick attack with done_* tied high: one cycle per stage.
    offer(3'b001, 1'b0);
    check("qa_move_code_load", move_code, 3'b001);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("qa_en_c%0d", k + 1), en_vec, exp_en[k]);
      check($sformatf("qa_done_c%0d", k + 1), turn_done, (k == 5));
      if (k < 5) tick();
    end
    tick();
    check("qa_ready_back", move_ready, 1);

    // Thunderbolt: decrement finishes 40 cycles after DECR entry; valid held while busy.
    done_decrement = 1'b0;
    offer(3'b010, 1'b0);
    tick();
    tick();
    tick();
    move_valid = 1'b1;
    move_sel   = 3'b100;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!decrement_en) break;
      n++;
      if (n == 41) done_decrement = 1'b1;
      tick();
    end
    check("tb_decr_cycles", n, 41);
    check("tb_draw_after_decr", en_vec, 5'b00001);
    check("tb_busy_ready", move_ready, 0);
    check("tb_busy_code_held", move_code, 3'b010);
    move_valid = 1'b0;
    tick();
    check("tb_finish", turn_done, 1);
    tick();

    // Invalid codes: straight to FINISH with err_move, no enables.
    offer(3'b011, 1'b0);
    check("err011_done", turn_done, 1);
    check("err011_flag", err_move, 1);
    check("err011_enables", en_vec, 5'b00000);
    tick();
    check("err011_ready_back", move_ready, 1);
    offer(3'b000, 1'b0);
    check("err000_done", turn_done, 1);
    check("err000_flag", err_move, 1);
    check("err000_enables", en_vec, 5'b00000);
    tick();
    check("err000_ready_back", move_ready, 1);

    // Reset while waiting in DRAW.
    done_damage = 1'b0;
    offer(3'b100, 1'b0);
    repeat (4) tick();
    check("rst_mid_in_draw", en_vec, 5'b00001);
    tick();
    reset = 1'b1;
    tick();
    check("rst_mid_enables", en_vec, 5'b00000);
    check("rst_mid_turn_done", turn_done, 0);
    check("rst_mid_move_code", move_code, 3'b000);
    reset = 1'b0;
    sb_q.delete();
    check("rst_mid_ready", move_ready, 1);
    done_damage = 1'b1;
    offer(3'b010, 1'b0);
    wait_done(lat);
    check("post_rst_latency", lat, 6);
    tick();

    // Watchdog: decrement never completes.
    done_decrement = 1'b0;
    offer(3'b001, WD);
    tick();
    tick();
    tick();
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (!decrement_en) break;
      n++;
      tick();
    end
`ifdef WATCHDOG_EN
    check("wd_decr_cycles", n, 16);
    check("wd_turn_done", turn_done, 1);
    check("wd_timeout", timeout, 1);
    tick();
    check("wd_ready_back", move_ready, 1);
`else
    check("nowd_decr_cycles", n, 60);
    check("nowd_still_decr", decrement_en, 1);
    check("nowd_no_timeout", {turn_done, timeout}, 2'b00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    check("nowd_ready_after_rst", move_ready, 1);
`endif
    done_decrement = 1'b1;

    // KO: game_over high through FINISH locks the controller.
    game_over = 1'b1;
    offer(3'b001, 1'b0);
    wait_done(lat);
    check("ko_latency", lat, 6);
    tick();
    check("ko_battle_over", battle_over, 1);
    move_valid = 1'b1;
    move_sel   = 3'b001;
    for (int i = 0; i < 100; i++) begin
      check("ko_ready_low", move_ready, 0);
      tick();
    end
    move_valid = 1'b0;
    check("ko_sticky", battle_over, 1);
    check("ko_enables_idle", en_vec, 5'b00000);

    // Reset clears the KO.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    game_over = 1'b0;
    check("ko_cleared", battle_over, 0);
    check("ko_ready_restored", move_ready, 1);
    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
